div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Sequences the multi-cycle divider used by the EXE stage. Detects DIV/DIVU in EX and pulses
//  the divider start. Stalls the pipeline until the quotient/remainder return, then holds the
//  HI/LO result until MEM accepts it. Also handles flush (exception/eret) mid-divide.
//  Sits between the decode-side control (alucontrol, valid, flush) and the divider/HI-LO datapath.
// PARAMETERS
//  DIV_CODE     5'b11010  alucontrol encoding for signed DIV
//  DIVU_CODE    5'b11011  alucontrol encoding for unsigned DIVU
//  MAX_CYCLES   40        watchdog limit on divider busy cycles; 0 disables the watchdog
// PORTS
//  clk              in   1   clock; all state on posedge
//  rst              in   1   synchronous, active-high reset
//  ex_valid_i       in   1   EX holds a valid (non-bubble) instruction
//  ex_alucontrol_i  in   5   EX ALU operation code
//  ex_divisor_i     in   32  forwarded rt operand (divisor)
//  flush_i          in   1   pipeline flush; kills the EX instruction
//  mem_stall_i      in   1   downstream stall; MEM cannot accept this cycle
//  div_ready_i      in   1   divider done, 1-cycle pulse
//  div_result_i     in   64  {remainder, quotient} from divider; valid with div_ready_i
//  div_start_o      out  1   divider start (level; high throughout RUN)
//  div_signed_o     out  1   1 = signed divide for the current op
//  div_annul_o      out  1   1-cycle abort pulse to divider on flush in RUN
//  stall_o          out  1   freeze IF/ID/EX while the divide is in progress
//  hilo_valid_o     out  1   hi_o/lo_o valid for the EX instruction
//  hi_o             out  32  remainder
//  lo_o             out  32  quotient
//  timeout_o        out  1   sticky watchdog flag; cleared only by rst
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; result registers 0; cycle counter 0.
//  - is_div = ex_valid_i & ~flush_i & (alucontrol==DIV_CODE | alucontrol==DIVU_CODE).
//  - FSM IDLE/RUN/DONE:
//    IDLE: is_div -> RUN. In the same cycle: stall_o=1 (combinational), latch div_signed_o, counter=0.
//    RUN: div_start_o=1, stall_o=1, counter++ each cycle.
//      flush_i -> IDLE; div_annul_o=1 for one cycle; result discarded.
//      else div_ready_i -> DONE; register div_result_i into {hi_o,lo_o}.
//    DONE: stall_o=0, hilo_valid_o=1.
//      Leave to IDLE on the first cycle with ~mem_stall_i (instruction advances).
//      Hold hi_o/lo_o unchanged while mem_stall_i.
//      flush_i in DONE -> IDLE, hilo_valid_o drops next cycle.
//  - Latency: divider cycles N (start to ready) -> stall_o high N+1 cycles; hilo_valid_o the cycle after ready.
//  - A new DIV cannot enter while in DONE: the same EX instruction is still present, so DONE->IDLE must
//    not re-trigger it. Re-arm only after one cycle with ~stall_o & ~mem_stall_i (EX contents changed).
//  - Flush has priority over div_ready_i in the same cycle. Flush in IDLE: no start.
//  - Watchdog (MAX_CYCLES!=0): counter==MAX_CYCLES in RUN -> timeout_o=1, div_annul_o pulse,
//    go DONE with hi_o=lo_o=0 so the pipeline cannot hang.
//  - Non-div ops, and ex_valid_i=0: outputs stay at their idle values; stall_o=0.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined:
//    is_div with ex_divisor_i==0 skips RUN and the divider (div_start_o stays 0).
//    Goes IDLE->DONE in one cycle with stall_o=1 for that cycle only.
//    Result: lo_o=32'hFFFFFFFF, hi_o=dividend-independent 0.
//  Not defined: divide-by-zero goes through the divider like any other operand; result is whatever
//  the divider returns.
// TESTING
//  - DIV 100/7, divider 34-cycle model -> stall_o 35 cycles, lo_o=14, hi_o=2, hilo_valid_o 1 cycle.
//  - DIVU 0xFFFFFFFF/2 -> div_signed_o=0, lo_o=0x7FFFFFFF, hi_o=1.
//  - DIV -7/2 with mem_stall_i=1 for 3 cycles after ready -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF,
//    held 4 cycles, no second start.
//  - Flush at RUN cycle 10 -> div_annul_o one pulse, IDLE next cycle, stall_o=0, hilo_valid_o never set.
//  - rst at RUN cycle 5 -> next cycle all outputs 0, state IDLE; a late div_ready_i pulse is ignored.
//  - DIV x/0 with DIV_ZERO_FAST_EN -> no div_start_o, stall_o 1 cycle, lo_o=0xFFFFFFFF, hi_o=0.
//    Without the macro: normal RUN path.
//  - Divider never returns ready, MAX_CYCLES=40 -> timeout_o=1 after 40 RUN cycles, pipeline released.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : div_issue_ctrl_if
// Brief    : EX-stage divide issue bundle between the pipeline, divider and the
//            div_issue_ctrl sequencer.
// Revision : 1.0  initial release
//==============================================================================
interface div_issue_ctrl_if;
    logic        ex_valid_i;
    logic [4:0]  ex_alucontrol_i;
    logic [31:0] ex_divisor_i;
    logic        flush_i;
    logic        mem_stall_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        div_start_o;
    logic        div_signed_o;
    logic        div_annul_o;
    logic        stall_o;
    logic        hilo_valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        timeout_o;

    modport slave (
        input  ex_valid_i, ex_alucontrol_i, ex_divisor_i, flush_i, mem_stall_i,
        input  div_ready_i, div_result_i,
        output div_start_o, div_signed_o, div_annul_o, stall_o, hilo_valid_o,
        output hi_o, lo_o, timeout_o
    );

    modport master (
        output ex_valid_i, ex_alucontrol_i, ex_divisor_i, flush_i, mem_stall_i,
        output div_ready_i, div_result_i,
        input  div_start_o, div_signed_o, div_annul_o, stall_o, hilo_valid_o,
        input  hi_o, lo_o, timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : div_issue_ctrl
// Brief    : Issues DIV/DIVU to the multi-cycle divider, stalls the pipeline
//            until the result returns and holds HI/LO until MEM accepts it.
// Config   : DIV_ZERO_FAST_EN - divide-by-zero bypasses the divider.
// Revision : 1.0  initial release
//==============================================================================
module div_issue_ctrl #(
    parameter logic [4:0]  DIV_CODE   = 5'b11010,
    parameter logic [4:0]  DIVU_CODE  = 5'b11011,
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic            clk,
    input  logic            rst,
    div_issue_ctrl_if.slave bus
);

    localparam int unsigned c_cnt_w = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [c_cnt_w-1:0] c_wdog_last =
        c_cnt_w'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_signed;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic                r_timeout;

    logic                w_is_div;
    logic                w_fast_zero;
    logic                w_wdog;
    logic                w_stall;
    logic                w_annul;
    logic                w_load;
    logic [63:0]         w_res;
    logic                w_timeout_set;

    assign w_is_div = bus.ex_valid_i & ~bus.flush_i &
                      ((bus.ex_alucontrol_i == DIV_CODE) | (bus.ex_alucontrol_i == DIVU_CODE));

`ifdef DIV_ZERO_FAST_EN
    assign w_fast_zero = w_is_div & (bus.ex_divisor_i == 32'd0);
`else
    logic w_unused_divisor;
    assign w_unused_divisor = |bus.ex_divisor_i;
    assign w_fast_zero      = 1'b0;
`endif

    // r_count holds the number of RUN cycles already completed, so the
    // watchdog fires on the MAX_CYCLES-th RUN cycle.
    assign w_wdog = (MAX_CYCLES != 0) && (r_count == c_wdog_last);

    always_comb begin
        w_state_next  = r_state;
        w_stall       = 1'b0;
        w_annul       = 1'b0;
        w_load        = 1'b0;
        w_res         = 64'd0;
        w_timeout_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_div) begin
                    w_stall = 1'b1;
                    if (w_fast_zero) begin
                        w_state_next = S_DONE;
                        w_load       = 1'b1;
                        w_res        = {32'd0, 32'hFFFF_FFFF};
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_stall = 1'b1;
                if (bus.flush_i) begin
                    w_annul      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (bus.div_ready_i) begin
                    w_load       = 1'b1;
                    w_res        = bus.div_result_i;
                    w_state_next = S_DONE;
                end else if (w_wdog) begin
                    w_annul       = 1'b1;
                    w_load        = 1'b1;
                    w_timeout_set = 1'b1;
                    w_state_next  = S_DONE;
                end
            end
            S_DONE: begin
                // Leaving DONE coincides with EX advancing, so the next IDLE
                // cycle always sees a new instruction and cannot re-issue.
                if (bus.flush_i || !bus.mem_stall_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_signed  <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_RUN) begin
                r_count <= r_count + c_cnt_w'(1);
            end else begin
                r_count <= '0;
            end
            if ((r_state == S_IDLE) && w_is_div) begin
                r_signed <= (bus.ex_alucontrol_i == DIV_CODE);
            end
            if (w_load) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.div_start_o  = (r_state == S_RUN);
    assign bus.div_signed_o = r_signed;
    assign bus.div_annul_o  = w_annul;
    assign bus.stall_o      = w_stall;
    assign bus.hilo_valid_o = (r_state == S_DONE);
    assign bus.hi_o         = r_hi;
    assign bus.lo_o         = r_lo;
    assign bus.timeout_o    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_div_issue_ctrl
// Brief    : Self-checking bench for div_issue_ctrl against a transaction-level
//            model of the divide issue sequence.
// Revision : 1.0  initial release
//==============================================================================
module tb_div_issue_ctrl;

    localparam logic [4:0] c_div  = 5'b11010;
    localparam logic [4:0] c_divu = 5'b11011;
    localparam int         c_max  = 40;

    logic clk = 1'b0;
    logic rst;

    div_issue_ctrl_if bus();

    div_issue_ctrl #(
        .DIV_CODE   (c_div),
        .DIVU_CODE  (c_divu),
        .MAX_CYCLES (c_max)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
    } instr_t;

    int checks = 0;
    int errors = 0;

    instr_t cur;
    bit     directed, never_ready, force_ready, chk_en;

    // model of the divide in flight / result held for the EX instruction
    bit          m_busy, m_hold, m_signed, m_timeout;
    int          m_cycles;
    logic [31:0] m_hi, m_lo;

    // inputs applied in the current cycle
    bit          s_fl, s_ms, s_rdy, s_rst, s_isdiv, e_stall;
    logic [63:0] s_res;

    int          obs_stall, obs_valid, obs_annul, obs_start_rise;
    bit          obs_signed, prev_start;
    logic [31:0] cap_hi, cap_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int lat);
        instr_t i;
        i.valid = 1'b1; i.op = op; i.a = a; i.b = b; i.lat = lat;
        return i;
    endfunction

    function automatic instr_t bubble();
        instr_t i;
        i.valid = 1'b0; i.op = 5'd0; i.a = 32'd0; i.b = 32'd0; i.lat = 1;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int     k;
        i.valid = ($urandom_range(9) < 8);
        k = $urandom_range(9);
        if (k < 4)      i.op = c_div;
        else if (k < 6) i.op = c_divu;
        else begin
            i.op = 5'($urandom_range(31));
            if (i.op == c_div || i.op == c_divu) i.op = 5'd0;
        end
        i.a = $urandom;
        case ($urandom_range(7))
            0:       i.b = 32'd0;
            1:       i.b = 32'($urandom_range(15));
            default: i.b = $urandom;
        endcase
        i.lat = ($urandom_range(49) == 0) ? 60 : $urandom_range(12, 1);
        return i;
    endfunction

    // Reference divider: {remainder, quotient}; x/0 returns {x, all ones}.
    function automatic logic [63:0] ref_div(input instr_t i);
        longint sa, sb, q, r;
        if (i.b == 32'd0) return {i.a, 32'hFFFF_FFFF};
        if (i.op == c_div) begin
            sa = longint'($signed(i.a));
            sb = longint'($signed(i.b));
        end else begin
            sa = longint'({32'd0, i.a});
            sb = longint'({32'd0, i.b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic clr_obs();
        obs_stall = 0; obs_valid = 0; obs_annul = 0; obs_start_rise = 0;
        obs_signed = 1'b0; prev_start = 1'b0; cap_hi = 32'hDEAD_BEEF; cap_lo = 32'hDEAD_BEEF;
    endtask

    task automatic drive(input bit fl, input bit ms, input bit rs);
        rst                 = rs;
        bus.flush_i         = fl;
        bus.mem_stall_i     = ms;
        bus.ex_valid_i      = cur.valid;
        bus.ex_alucontrol_i = cur.op;
        bus.ex_divisor_i    = cur.b;
        if (m_busy && !never_ready && (m_cycles + 1 == cur.lat)) begin
            bus.div_ready_i  = 1'b1;
            bus.div_result_i = ref_div(cur);
        end else begin
            bus.div_ready_i  = force_ready || (!directed && !m_busy && $urandom_range(9) == 0);
            bus.div_result_i = {$urandom, $urandom};
        end
        s_fl = fl; s_ms = ms; s_rst = rs;
        s_rdy = bus.div_ready_i; s_res = bus.div_result_i;
        s_isdiv = cur.valid && !fl && (cur.op == c_div || cur.op == c_divu);
    endtask

    task automatic check_cycle();
        bit e_annul;
        e_stall = m_busy || (!m_busy && !m_hold && s_isdiv);
        e_annul = m_busy && (s_fl || (!s_rdy && (m_cycles + 1 == c_max)));
        if (!chk_en) return;
        chk("stall", 32'(bus.stall_o), 32'(e_stall));
        chk("start", 32'(bus.div_start_o), 32'(m_busy));
        chk("annul", 32'(bus.div_annul_o), 32'(e_annul));
        chk("hilo_valid", 32'(bus.hilo_valid_o), 32'(m_hold));
        chk("timeout", 32'(bus.timeout_o), 32'(m_timeout));
        chk("hi", bus.hi_o, m_hi);
        chk("lo", bus.lo_o, m_lo);
        if (m_busy) chk("signed", 32'(bus.div_signed_o), 32'(m_signed));
        obs_stall += int'(bus.stall_o);
        obs_valid += int'(bus.hilo_valid_o);
        obs_annul += int'(bus.div_annul_o);
        if (bus.div_start_o && !prev_start) obs_start_rise++;
        prev_start = bus.div_start_o;
        if (bus.div_start_o) obs_signed = obs_signed | bus.div_signed_o;
        if (bus.hilo_valid_o) begin
            cap_hi = bus.hi_o;
            cap_lo = bus.lo_o;
        end
    endtask

    task automatic commit();
        if (s_rst) begin
            m_busy = 0; m_hold = 0; m_signed = 0; m_timeout = 0; m_cycles = 0;
            m_hi = 32'd0; m_lo = 32'd0;
            cur = bubble();
            return;
        end
        if (m_busy) begin
            if (s_fl) begin
                m_busy = 0;
            end else if (s_rdy) begin
                m_busy = 0; m_hold = 1; m_hi = s_res[63:32]; m_lo = s_res[31:0];
            end else if (m_cycles + 1 == c_max) begin
                m_busy = 0; m_hold = 1; m_hi = 32'd0; m_lo = 32'd0; m_timeout = 1;
            end else begin
                m_cycles++;
            end
        end else if (m_hold) begin
            if (s_fl || !s_ms) m_hold = 0;
        end else if (s_isdiv) begin
            m_signed = (cur.op == c_div);
`ifdef DIV_ZERO_FAST_EN
            if (cur.b == 32'd0) begin
                m_hold = 1; m_hi = 32'd0; m_lo = 32'hFFFF_FFFF;
            end else begin
                m_busy = 1; m_cycles = 0;
            end
`else
            m_busy = 1; m_cycles = 0;
`endif
        end
        // the pipeline moves EX on when nothing holds it, or kills it on flush
        if (s_fl || (!e_stall && !s_ms)) begin
            cur = directed ? bubble() : rand_instr();
        end
    endtask

    task automatic cycle(input bit fl, input bit ms, input bit rs);
        drive(fl, ms, rs);
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic run(input int n, input bit fl, input bit ms);
        for (int i = 0; i < n; i++) cycle(fl, ms, 1'b0);
    endtask

    task automatic do_reset();
        chk_en = 0;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk_en = 1;
    endtask

    initial begin
        directed = 1; never_ready = 0; force_ready = 0; chk_en = 0;
        cur = bubble();
        clr_obs();
        do_reset();

        // reset state
        clr_obs();
        run(2, 1'b0, 1'b0);
        chk("reset_hi", bus.hi_o, 32'd0);
        chk("reset_stall_cnt", 32'(obs_stall), 32'd0);

        // DIV 100/7 with a 34-cycle divider
        cur = mk(c_div, 32'd100, 32'd7, 34);
        clr_obs();
        run(45, 1'b0, 1'b0);
        chk("t1_stall_cycles", 32'(obs_stall), 32'd35);
        chk("t1_valid_cycles", 32'(obs_valid), 32'd1);
        chk("t1_lo", cap_lo, 32'd14);
        chk("t1_hi", cap_hi, 32'd2);

        // DIVU 0xFFFFFFFF/2
        cur = mk(c_divu, 32'hFFFF_FFFF, 32'd2, 5);
        clr_obs();
        run(12, 1'b0, 1'b0);
        chk("t2_signed", 32'(obs_signed), 32'd0);
        chk("t2_lo", cap_lo, 32'h7FFF_FFFF);
        chk("t2_hi", cap_hi, 32'd1);

        // DIV -7/2 with MEM stalled for 3 cycles after ready
        cur = mk(c_div, 32'hFFFF_FFF9, 32'd2, 6);
        clr_obs();
        run(7, 1'b0, 1'b0);
        run(3, 1'b0, 1'b1);
        run(10, 1'b0, 1'b0);
        chk("t3_lo", cap_lo, 32'hFFFF_FFFD);
        chk("t3_hi", cap_hi, 32'hFFFF_FFFF);
        chk("t3_valid_cycles", 32'(obs_valid), 32'd4);
        chk("t3_starts", 32'(obs_start_rise), 32'd1);

        // flush on RUN cycle 10
        cur = mk(c_div, 32'd50, 32'd3, 30);
        clr_obs();
        run(10, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        run(40, 1'b0, 1'b0);
        chk("t4_annul_pulses", 32'(obs_annul), 32'd1);
        chk("t4_valid_cycles", 32'(obs_valid), 32'd0);
        chk("t4_stall_cycles", 32'(obs_stall), 32'd11);

        // reset on RUN cycle 5, then a late ready pulse
        cur = mk(c_div, 32'd77, 32'd5, 20);
        run(5, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        clr_obs();
        force_ready = 1;
        cycle(1'b0, 1'b0, 1'b0);
        force_ready = 0;
        run(20, 1'b0, 1'b0);
        chk("t5_stall_cycles", 32'(obs_stall), 32'd0);
        chk("t5_starts", 32'(obs_start_rise), 32'd0);
        chk("t5_valid_cycles", 32'(obs_valid), 32'd0);
        chk("t5_lo", bus.lo_o, 32'd0);

        // divide by zero
        cur = mk(c_div, 32'd123, 32'd0, 4);
        clr_obs();
        run(12, 1'b0, 1'b0);
`ifdef DIV_ZERO_FAST_EN
        chk("t6_starts", 32'(obs_start_rise), 32'd0);
        chk("t6_stall_cycles", 32'(obs_stall), 32'd1);
        chk("t6_hi", cap_hi, 32'd0);
`else
        chk("t6_starts", 32'(obs_start_rise), 32'd1);
        chk("t6_stall_cycles", 32'(obs_stall), 32'd5);
        chk("t6_hi", cap_hi, 32'd123);
`endif
        chk("t6_lo", cap_lo, 32'hFFFF_FFFF);

        // divider never returns: watchdog
        never_ready = 1;
        cur = mk(c_div, 32'd9, 32'd3, 1);
        clr_obs();
        run(60, 1'b0, 1'b0);
        never_ready = 0;
        chk("t7_timeout", 32'(bus.timeout_o), 32'd1);
        chk("t7_stall_cycles", 32'(obs_stall), 32'd41);
        chk("t7_annul_pulses", 32'(obs_annul), 32'd1);
        chk("t7_valid_cycles", 32'(obs_valid), 32'd1);
        chk("t7_lo", cap_lo, 32'd0);
        do_reset();
        run(1, 1'b0, 1'b0);
        chk("t7_timeout_cleared", 32'(bus.timeout_o), 32'd0);

        // randomized instruction stream
        directed = 0;
        cur = rand_instr();
        for (int n = 0; n < 4000; n++) begin
            cycle($urandom_range(39) == 0, $urandom_range(2) == 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
